param_mem_ctrl: RTL

//  Parametrised single-port synchronous memory. It is the next generation of the 16x8 test-memory DUT.

---
 rtl/param_mem_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/param_mem_ctrl.sv
// Parametrised single-port synchronous RAM with byte-lane writes, pipelined reads,
// an optional zero-fill sweep after reset and a dropped-request error pulse.
module param_mem_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    write_en,
  input  logic                    read_en,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [DATA_WIDTH-1:0]   data_wr,
  output logic [DATA_WIDTH-1:0]   data_rd,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    drop_err
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NLANES = DATA_WIDTH / 8;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("param_mem_ctrl: RD_LATENCY must be in 1..4");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("param_mem_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic {INIT, READY} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic                  busy_q;
  logic                  drop_err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] pipe_q [RD_LATENCY];

  logic ready;
  logic rd_accept;

  assign ready     = (state_q == READY);
  assign rd_accept = ready & read_en;
  assign cnt_d     = cnt_q + 1'b1;

  // The sweep and normal writes share the one write port, so both live here.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err_q <= 1'b0;
      cnt_q      <= '0;
      if (CLEAR_ON_RST) begin
        state_q <= INIT;
        busy_q  <= 1'b1;
      end else begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end else begin
      drop_err_q <= 1'b0;
      case (state_q)
        INIT: begin
          mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
          cnt_q      <= cnt_d;
          drop_err_q <= write_en | read_en;
          if (cnt_q == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          if (write_en) begin
            for (int i = 0; i < NLANES; i++) begin
              if (byte_en[i]) mem_q[address][8*i +: 8] <= data_wr[8*i +: 8];
            end
          end
        end
        default: begin
          state_q <= READY;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stage data only moves with a valid token, so the last stage holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      vld_q[0] <= rd_accept;
      if (rd_accept) pipe_q[0] <= mem_q[address];
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign data_rd  = pipe_q[RD_LATENCY-1];
  assign rd_valid = vld_q[RD_LATENCY-1];
  assign busy     = busy_q;
  assign drop_err = drop_err_q;

endmodule
